inout_sram_stream_reader: RTL and testbench
===========================================

Name: inout_sram_stream_reader

Overview:
- Initiator on sp_ram_intf that drives the 384 kB InOut SRAM, 196608 16-bit words, word addresses 0x00000..0x2FFFF.
- On a start command it reads a contiguous run of words and streams them on a valid/ready output port.
- Handles the SRAM's 1-cycle read latency, keeping a small FIFO so backpressure never drops or duplicates a word.
- Feeds the compute datapath with activations and weights.

Parameters:
- FIFO_DEPTH, 2, output buffer entries; must be >= 2.
- ADDR_W, 18, SRAM word-address width.
- LEN_W, 19, transfer length width in words.
- MAX_ADDR, 18'h2FFFF, last valid word address.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  1-cycle command strobe; sampled only when busy=0.
- base_addr  in  ADDR_W  first word address, sampled with start.
- len  in  LEN_W  word count, sampled with start.
- abort  in  1  synchronous cancel of the current transfer.
- busy  out  1  high from the cycle after an accepted start until the last beat is handed off.
- done  out  1  1-cycle pulse after the last beat handshake, or for len=0.
- err  out  1  1-cycle pulse when a command is rejected.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts a beat.
- out_data  out  16  read word.
- out_last  out  1  marks the final beat of the transfer.
- mem  sp_ram_intf.master  -  SRAM port: cs, oe, addr[31:0], W_req (active-low write), W_data, R_data.

Behaviour:
- Clock and reset: one clock, clk; reset rstn is asynchronous, active-low.
- Reset values: cs=0, oe=0, addr=0, W_req=1, W_data=0, busy=0, done=0, err=0, out_valid=0, out_last=0. FIFO empty, state IDLE.
- Never writes: W_req is held at 1, W_data at 0, and addr[31:18] at 0. out_data = R_data[15:0]; upper bits are ignored.
- Command checks, evaluated in IDLE when start=1:
  - base_addr + len - 1 > MAX_ADDR, computed 19-bit with no wrap: err pulse next cycle, no SRAM access, stay IDLE.
  - len=0: done pulse next cycle, busy stays 0.
  - Otherwise go to RUN; busy=1 next cycle.
- States:
  - IDLE -> RUN on a valid command.
  - RUN -> DRAIN once len reads have been issued.
  - DRAIN -> IDLE when the out_last beat completes its handshake; done=1 in the following cycle.
- Issue timing: a read is issued in cycle t with cs=1 and addr=current word. In t+1, oe=1 and R_data is captured into the FIFO at the end of t+1.
- Issue condition: fifo_count + inflight - pop_now < FIFO_DEPTH, where pop_now = out_valid & out_ready. This gives zero overflow and 1 word/cycle throughput when out_ready is held high.
- Latency: start at cycle 0 gives cs/addr=base at cycle 1, oe at cycle 2, and out_valid with word[base] at cycle 3.
- Address increments by 1 per issued read and never passes base+len-1. cs=0 in cycles with no issue; oe=0 whenever no read is in flight.
- Output stream:
  - FIFO head drives out_data and out_valid.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - out_last=1 only on beat number len.
- start while busy=1 is ignored with no err.
- abort (any state):
  - next cycle: state IDLE, FIFO flushed, inflight cleared, out_valid=0, cs=0, busy=0, no done.
  - An in-flight read result arriving after abort is discarded, with oe still driven for that cycle.
  - abort together with start in IDLE: abort wins and the command is dropped.
- Reset mid-transfer returns every output to its reset value immediately.

Decomposition:
- Package inout_sram_pkg:
  - ADDR_W, LEN_W, MAX_ADDR, DATA_W=16 constants.
  - rd_state_e enum {IDLE, RUN, DRAIN}.
- Sub-module stream_fifo: synchronous FIFO with parameters DEPTH and WIDTH = DATA_W+1 (data plus last flag), ports push/pop/count/full/empty, flush input.

Test Plan:
- base=0x00010, len=4, out_ready=1: cs at cycles 1-4 with addr 0x10-0x13; out_valid cycles 3-6 with words mem[0x10..0x13]; out_last at cycle 6; done at 7.
- base=0x07FFE, len=4, crossing the 64 kB bank boundary, with out_ready toggling 1,0,0,1...: 4 beats in order mem[0x7FFE..0x8001], no duplicates, data stable during stalls, cs never issued while the FIFO is full.
- base=0x2FFFF, len=1: one beat, out_last=1, done. base=0x2FFFF, len=2: err pulse, cs never asserted, busy=0.
- len=0: done pulse next cycle, no cs, no out_valid.
- len=100, abort asserted at cycle 10: next cycle busy=0, out_valid=0, cs=0, no done. A new start with base=0x100, len=2 then yields exactly 2 beats.
- rstn low for 1 cycle mid-transfer: all outputs at reset values in that cycle. start while busy is ignored, with the transfer completing its original length.

Source files
------------

// File: rtl/inout_sram_stream_reader_pkg.sv
// Shared constants and state type for the InOut SRAM stream reader.
package inout_sram_pkg;
  localparam int              ADDR_W   = 18;
  localparam int              LEN_W    = 19;
  localparam logic [17:0]     MAX_ADDR = 18'h2FFFF;
  localparam int              DATA_W   = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_e;
endpackage

// File: rtl/sp_ram_intf.sv
// Single-port SRAM bus: W_req is an active-low write request.
interface sp_ram_intf;
  logic        cs;
  logic        oe;
  logic [31:0] addr;
  logic        W_req;
  logic [31:0] W_data;
  logic [31:0] R_data;

  modport master (output cs, oe, addr, W_req, W_data, input R_data);
  modport slave  (input cs, oe, addr, W_req, W_data, output R_data);
endinterface

// File: rtl/inout_sram_stream_reader_fifo.sv
// Small synchronous FIFO holding {last, data} beats; flush empties it in one cycle.
module stream_fifo
  import inout_sram_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = DATA_W + 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wr, w_rd;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (r_cnt == CNT_W'(DEPTH));
  assign empty    = (r_cnt == '0);
  assign count    = r_cnt;
  assign w_wr     = push & ~full;
  assign w_rd     = pop & ~empty;
  assign pop_data = r_mem[r_rd];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= nxt(r_wr);
      if (w_rd) r_rd <= nxt(r_rd);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !flush) r_mem[r_wr] <= push_data;
  end
endmodule

// File: rtl/inout_sram_stream_reader.sv
// Reads a contiguous run of 16-bit words from the InOut SRAM and streams them
// on valid/ready; issue is throttled so the 1-cycle read latency never overflows the FIFO.
module inout_sram_stream_reader #(
  parameter int                FIFO_DEPTH = 2,
  parameter int                ADDR_W     = inout_sram_pkg::ADDR_W,
  parameter int                LEN_W      = inout_sram_pkg::LEN_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR   = inout_sram_pkg::MAX_ADDR
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 base_addr,
  input  logic [LEN_W-1:0]                  len,
  input  logic                              abort,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [inout_sram_pkg::DATA_W-1:0] out_data,
  output logic                              out_last,
  sp_ram_intf.master                        mem
);
  import inout_sram_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int EW    = ((LEN_W > ADDR_W) ? LEN_W : ADDR_W) + 1;
  localparam int FW    = DATA_W + 1;

  rd_state_e         r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remain;
  logic              r_rd_pend, r_rd_keep, r_rd_last, r_done, r_err;
  logic              w_accept, w_zero, w_bad, w_go, w_issue, w_room;
  logic              w_pop, w_push, w_fin, w_empty, w_full;
  logic [EW-1:0]     w_end;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_occ;
  logic [FW-1:0]     w_head;
  logic              w_unused;

  assign w_accept = (r_state == IDLE) & start & ~abort;
  assign w_zero   = (len == '0);
  // base+len-1 > MAX rewritten as base+len > MAX+1, wide enough never to wrap
  assign w_end    = EW'(base_addr) + EW'(len);
  assign w_bad    = w_end > (EW'(MAX_ADDR) + EW'(1));
  assign w_go     = w_accept & ~w_zero & ~w_bad;

  assign w_pop  = ~w_empty & out_ready;
  assign w_fin  = w_pop & w_head[DATA_W];
  assign w_occ  = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_rd_keep) - (CNT_W+1)'(w_pop);
  assign w_room = w_occ < (CNT_W+1)'(FIFO_DEPTH);
  // a result returning in the abort cycle is dropped along with the flush
  assign w_push = r_rd_keep & ~abort;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_go) w_next = RUN;
      RUN:     if (w_issue && r_remain == LEN_W'(1)) w_next = DRAIN;
      DRAIN:   if (w_fin) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

  always_comb begin
    w_issue = 1'b0;
    busy    = 1'b0;
    case (r_state)
      RUN: begin
        w_issue = w_room;
        busy    = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr    <= '0;
      r_remain  <= '0;
      r_rd_pend <= 1'b0;
      r_rd_keep <= 1'b0;
      r_rd_last <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rd_pend <= w_issue;
      r_rd_keep <= w_issue & ~abort;
      r_rd_last <= w_issue & (r_remain == LEN_W'(1));
      r_done    <= (w_accept & w_zero) | ((r_state == DRAIN) & w_fin & ~abort);
      r_err     <= w_accept & ~w_zero & w_bad;
      if (w_go) begin
        r_addr   <= base_addr;
        r_remain <= len;
      end else if (w_issue) begin
        r_remain <= r_remain - LEN_W'(1);
        // hold on the final word so addr never runs past base+len-1
        if (r_remain != LEN_W'(1)) r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  stream_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FW)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (abort),
    .push      (w_push),
    .push_data ({r_rd_last, mem.R_data[DATA_W-1:0]}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign mem.cs     = w_issue;
  assign mem.oe     = r_rd_pend;
  assign mem.addr   = 32'(r_addr);
  assign mem.W_req  = 1'b1;
  assign mem.W_data = '0;

  assign done      = r_done;
  assign err       = r_err;
  assign out_valid = ~w_empty;
  assign out_data  = w_head[DATA_W-1:0];
  assign out_last  = ~w_empty & w_head[DATA_W];

  assign w_unused = ^{mem.R_data[31:DATA_W], w_full};
endmodule

// File: tb/tb_inout_sram_stream_reader.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_inout_sram_stream_reader;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [17:0] base_addr = '0;
  logic [18:0] len = '0;
  logic        abort = 1'b0;
  logic        busy, done, err, out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [31:0] rdat = '0;

  sp_ram_intf u_mem();

  inout_sram_stream_reader dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .len(len),
    .abort(abort), .busy(busy), .done(done), .err(err), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .mem(u_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] f(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A ^ {14'h0, a[17:16]};
  endfunction

  // SRAM model: 1-cycle read latency, junk in the upper half of R_data
  always @(posedge clk) if (u_mem.cs) rdat <= {16'hBEEF, f(u_mem.addr[17:0])};
  assign u_mem.R_data = rdat;

  int n_chk = 0, n_err = 0;
  int n_cs = 0, n_done = 0, n_errp = 0, n_vcyc = 0, n_beats = 0;
  int iss_c = 0, pop_c = 0, pn;
  bit occ_en = 0, rdy_pat = 0;
  logic [16:0] exp_q[$];
  logic [16:0] e;
  logic        prev_stall = 0, prev_last;
  logic [15:0] prev_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic expect_run(input logic [17:0] b, input int l);
    for (int i = 0; i < l; i++) exp_q.push_back({(i == l-1), f(b + 18'(i))});
  endtask

  task automatic do_start(input logic [17:0] b, input logic [18:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string nm);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  // out_ready pattern 1,0,0,1 repeating
  initial begin
    logic [3:0] pat;
    int pidx;
    pat = 4'b1001;
    pidx = 0;
    forever begin
      @(posedge clk); #1;
      if (rdy_pat) begin
        out_ready = pat[pidx];
        pidx = (pidx + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (u_mem.cs) n_cs++;
      if (done) n_done++;
      if (err) n_errp++;
      if (out_valid) n_vcyc++;
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL beat_unexpected got=%h last=%b want=none", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {15'h0, out_last, out_data}, {15'h0, e});
        end
        n_beats++;
      end
      if (occ_en) begin
        pn = (out_valid && out_ready) ? 1 : 0;
        if (u_mem.cs) begin
          chk("occ_at_issue", 32'((iss_c - pop_c - pn) < 2), 32'd1);
          iss_c++;
        end
        pop_c += pn;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else prev_stall = 0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_cs, s_done, s_errp, s_vcyc, s_beats;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_cs", 32'(u_mem.cs), 0);
    chk("rst_oe", 32'(u_mem.oe), 0);
    chk("rst_addr", u_mem.addr, 0);
    chk("rst_wreq", 32'(u_mem.W_req), 1);
    chk("rst_wdata", u_mem.W_data, 0);
    chk("rst_busy_done_err", {29'h0, busy, done, err}, 0);
    chk("rst_valid_last", {30'h0, out_valid, out_last}, 0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // T1: base 0x10, len 4, always ready: exact cycle table
    expect_run(18'h10, 4);
    do_start(18'h10, 19'd4);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("t1_cs_c%0d", k), 32'(u_mem.cs), 32'(k <= 4));
      if (k <= 4) chk($sformatf("t1_addr_c%0d", k), u_mem.addr, 32'h10 + 32'(k-1));
      chk($sformatf("t1_oe_c%0d", k), 32'(u_mem.oe), 32'(k >= 2 && k <= 5));
      chk($sformatf("t1_valid_c%0d", k), 32'(out_valid), 32'(k >= 3 && k <= 6));
      chk($sformatf("t1_last_c%0d", k), 32'(out_last), 32'(k == 6));
      chk($sformatf("t1_done_c%0d", k), 32'(done), 32'(k == 7));
      chk($sformatf("t1_busy_c%0d", k), 32'(busy), 32'(k <= 6));
    end
    chk("t1_q_empty", 32'(exp_q.size()), 0);
    repeat (3) @(posedge clk);

    // T2: bank-crossing run with backpressure
    s_beats = n_beats;
    iss_c = 0; pop_c = 0; occ_en = 1; rdy_pat = 1;
    expect_run(18'h07FFE, 4);
    do_start(18'h07FFE, 19'd4);
    wait_done(60, "t2_done");
    occ_en = 0; rdy_pat = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    chk("t2_beats", 32'(n_beats - s_beats), 4);
    chk("t2_q_empty", 32'(exp_q.size()), 0);
    repeat (3) @(posedge clk);

    // T3a: last word, len 1
    s_beats = n_beats;
    expect_run(18'h2FFFF, 1);
    do_start(18'h2FFFF, 19'd1);
    wait_done(20, "t3a_done");
    chk("t3a_beats", 32'(n_beats - s_beats), 1);
    repeat (3) @(posedge clk);

    // T3b: range error
    s_cs = n_cs; s_errp = n_errp;
    do_start(18'h2FFFF, 19'd2);
    @(negedge clk);
    chk("t3b_err", 32'(err), 1);
    chk("t3b_busy", 32'(busy), 0);
    repeat (4) @(negedge clk);
    chk("t3b_no_cs", 32'(n_cs - s_cs), 0);
    chk("t3b_err_once", 32'(n_errp - s_errp), 1);

    // T4: len 0
    s_cs = n_cs; s_vcyc = n_vcyc; s_errp = n_errp;
    do_start(18'h00123, 19'd0);
    @(negedge clk);
    chk("t4_done", 32'(done), 1);
    chk("t4_busy", 32'(busy), 0);
    repeat (4) @(negedge clk);
    chk("t4_no_cs", 32'(n_cs - s_cs), 0);
    chk("t4_no_valid", 32'(n_vcyc - s_vcyc), 0);
    chk("t4_no_err", 32'(n_errp - s_errp), 0);

    // T5: abort at cycle 10 of a len-100 run; words 0..7 are handed off first
    expect_run(18'h0, 8);
    exp_q[7][16] = 1'b0;
    do_start(18'h0, 19'd100);
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    s_done = n_done;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_cs", 32'(u_mem.cs), 0);
    chk("t5_oe_discard", 32'(u_mem.oe), 1);
    chk("t5_q_empty", 32'(exp_q.size()), 0);
    repeat (4) @(negedge clk);
    chk("t5_oe_idle", 32'(u_mem.oe), 0);
    chk("t5_no_done", 32'(n_done - s_done), 0);
    s_beats = n_beats;
    expect_run(18'h100, 2);
    do_start(18'h100, 19'd2);
    wait_done(20, "t5_restart_done");
    chk("t5_restart_beats", 32'(n_beats - s_beats), 2);
    repeat (3) @(posedge clk);

    // T6: reset mid-transfer, then start while busy is ignored
    expect_run(18'h200, 20);
    do_start(18'h200, 19'd20);
    repeat (4) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("t6_rst_cs_oe", {30'h0, u_mem.cs, u_mem.oe}, 0);
    chk("t6_rst_addr", u_mem.addr, 0);
    chk("t6_rst_wreq", 32'(u_mem.W_req), 1);
    chk("t6_rst_busy_done_err", {29'h0, busy, done, err}, 0);
    chk("t6_rst_valid_last", {30'h0, out_valid, out_last}, 0);
    @(posedge clk); #1 rstn = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    s_beats = n_beats; s_errp = n_errp;
    expect_run(18'h300, 6);
    do_start(18'h300, 19'd6);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; base_addr = 18'h0; len = 19'd1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(40, "t6_done");
    repeat (5) @(negedge clk);
    chk("t6_beats", 32'(n_beats - s_beats), 6);
    chk("t6_no_err", 32'(n_errp - s_errp), 0);
    chk("t6_q_empty", 32'(exp_q.size()), 0);
    chk("t6_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
